stage2_conv_window_gen: RTL and testbench
=========================================

Name: stage2_conv_window_gen

Overview:
Streaming 5x5 sliding-window generator in front of stage2_cnn_kernel. Accepts one signed stage-2 feature-map pixel per valid cycle, in raster order, for an IW x IH single-channel map. Buffers KY-1 previous rows and emits a flattened KX x KY window for every valid output position (stride 1, no padding). The output bus matches the kernel's i_in_fmap packing exactly.

Parameters:
IW, 12, input map width in pixels
IH, 12, input map height in pixels
KX, 5, window width (`KX)
KY, 5, window height (`KY)
IBW, 20, pixel bit width (`ST2_Conv_IBW)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
i_in_valid  in  1  pixel strobe; one pixel accepted per high cycle
i_in_pixel  in  IBW  signed pixel, raster order (row-major, col fastest)
o_ot_valid  out  1  window valid, feeds kernel i_in_valid
o_ot_fmap  out  KX*KY*IBW  window; element k = ky*KX+kx at bits [k*IBW +: IBW]
o_ot_last  out  1  high with o_ot_valid on the final window of a frame

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - o_ot_valid = 0, o_ot_last = 0, o_ot_fmap = 0.
  - Column and row counters = 0.
  - Line-buffer contents are don't-care; valid gating masks any stale data.
- Counters:
  - col advances on each accepted pixel and wraps IW-1 -> 0. On that wrap, row advances.
  - row wraps IH-1 -> 0, which starts the next frame.
  - Counters hold when i_in_valid = 0.
- Line buffer: KY-1 rows x IW entries x IBW bits, addressed by col.
  - On an accepted pixel at (r,c), form a column vector with entries ky = 0..KY-2 taken from lb[ky][c] (rows r-4..r-1) and entry ky = KY-1 = the incoming pixel.
  - Write back with a shift: lb[ky][c] <= lb[ky+1][c] for ky < KY-2, and lb[KY-2][c] <= pixel.
- Window register (KX x KY):
  - On an accepted pixel, shift every row left by one column (kx <- kx+1).
  - Insert the column vector at kx = KX-1.
  - Holds when idle.
- Output timing:
  - o_ot_valid is registered; it goes high the cycle after a pixel accepted with r >= KY-1 and c >= KX-1.
  - Latency is 1 cycle from the completing pixel.
  - o_ot_fmap is the window register output, valid in the same cycle as o_ot_valid.
  - o_ot_last is registered alongside o_ot_valid for the pixel at (IH-1, IW-1).
- Valid windows per frame: (IH-KY+1)*(IW-KX+1) = 64 at the defaults.
- Gaps: idle cycles on i_in_valid change no state. o_ot_valid returns to 0 the cycle after an idle input cycle. Window content is unaffected by gaps.
- Row boundary: columns c < KX-1 hold stale data from the previous row; valid is suppressed there.
- Back-to-back frames with no idle cycle are supported. Line-buffer data from the previous frame is masked by the row < KY-1 gating.
- Reset mid-frame: the next accepted pixel is treated as (0,0). No partial window is emitted.
- No backpressure. The downstream kernel must accept every o_ot_valid.
- Data is passed through unmodified; the sign is preserved bit-exactly.

Decomposition:
- Shared defines: KX, KY, ST2_Conv_IBW, and the stage-2 map dimensions ST2_IW / ST2_IH.
- One natural sub-module: stage2_line_buffer, a column-addressed, (KY-1)-row shift memory with read-before-write.
- The window shift register and the counters stay in the top module.

Test Plan:
- Ramp frame: pixel(r,c) = r*12+c+1, continuous valid from cycle 0.
  - First o_ot_valid at cycle 53, with element 0 = 1, element 12 = 27, element 24 = 53.
  - Exactly 64 valid windows per frame.
  - o_ot_last only on window 64, whose element 24 = 144 and element 0 = 92.
- Random idle gaps (30% low) on the same ramp -> identical sequence of 64 windows, each o_ot_valid exactly 1 cycle after its completing pixel; o_ot_valid is never high during a gap-following cycle without a new pixel.
- Two back-to-back frames, frame 2 = ramp + 1000 -> frame-2 first window at cycle 197 (144 + 53), element 0 = 1001, with no frame-1 data leaking into any element.
- Negative pixels: ramp negated (-1, -2, ...) -> element 24 of the first window = -53 (20-bit two's complement 0xFFFCB); all bits match the input.
- Reset asserted for 1 cycle after 70 pixels, then a fresh ramp -> no o_ot_valid until the 53rd cycle after the restart; the first window equals the clean-start case.
- Reset held high while i_in_valid = 1 -> o_ot_valid, o_ot_last and o_ot_fmap stay 0 throughout.

Source files
------------

// File: rtl/stage2_conv_window_gen_pkg.sv
// ============================================================================
// stage2_conv_window_gen_pkg : shared stage-2 window/kernel dimensions
// Revision : 1.0
// ============================================================================
`default_nettype none

package stage2_conv_window_gen_pkg;

   localparam int ST2_KX       = 5;
   localparam int ST2_KY       = 5;
   localparam int ST2_CONV_IBW = 20;
   localparam int ST2_IW       = 12;
   localparam int ST2_IH       = 12;

   // Counter/address width that never collapses to zero bits.
   function automatic int cnt_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/stage2_line_buffer.sv
// ============================================================================
// stage2_line_buffer : column-addressed (ROWS)-row shift memory, read-before-write
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage2_line_buffer #(
   parameter int DEPTH = 12,
   parameter int ROWS  = 4,
   parameter int IBW   = 20,
   parameter int AW    = 4
) (
   input  logic                clk,
   input  logic                i_wr_en,
   input  logic [AW-1:0]       i_col,
   input  logic [IBW-1:0]      i_pixel,
   output logic [ROWS*IBW-1:0] o_col_vec
);

   // Row 0 holds the oldest buffered line, row ROWS-1 the most recent one.
   logic [IBW-1:0] r_mem [ROWS][DEPTH];

   generate
      for (genvar ry = 0; ry < ROWS; ry++) begin : g_rd
         assign o_col_vec[ry*IBW +: IBW] = r_mem[ry][i_col];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         for (int ry = 0; ry < ROWS-1; ry++) begin
            r_mem[ry][i_col] <= r_mem[ry+1][i_col];
         end
         r_mem[ROWS-1][i_col] <= i_pixel;
      end
   end

endmodule

`default_nettype wire

// File: rtl/stage2_conv_window_gen.sv
// ============================================================================
// stage2_conv_window_gen : streaming KXxKY sliding-window generator, stride 1
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage2_conv_window_gen
   import stage2_conv_window_gen_pkg::*;
#(
   parameter int IW  = ST2_IW,
   parameter int IH  = ST2_IH,
   parameter int KX  = ST2_KX,
   parameter int KY  = ST2_KY,
   parameter int IBW = ST2_CONV_IBW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_in_valid,
   input  logic [IBW-1:0]        i_in_pixel,
   output logic                  o_ot_valid,
   output logic [KX*KY*IBW-1:0]  o_ot_fmap,
   output logic                  o_ot_last
);

   localparam int CW = cnt_width(IW);
   localparam int RW = cnt_width(IH);

   logic [CW-1:0]         r_col;
   logic [RW-1:0]         r_row;
   logic                  r_valid;
   logic                  r_last;
   logic [IBW-1:0]        r_win [KY][KX];
   logic [(KY-1)*IBW-1:0] w_lb_col;
   logic [IBW-1:0]        w_col_vec [KY];
   logic                  w_col_wrap;
   logic                  w_row_wrap;
   logic                  w_win_done;

   stage2_line_buffer #(
      .DEPTH (IW),
      .ROWS  (KY-1),
      .IBW   (IBW),
      .AW    (CW)
   ) u_line_buffer (
      .clk       (clk),
      .i_wr_en   (i_in_valid),
      .i_col     (r_col),
      .i_pixel   (i_in_pixel),
      .o_col_vec (w_lb_col)
   );

   generate
      for (genvar ky = 0; ky < KY-1; ky++) begin : g_colvec
         assign w_col_vec[ky] = w_lb_col[ky*IBW +: IBW];
      end
   endgenerate
   assign w_col_vec[KY-1] = i_in_pixel;

   assign w_col_wrap = (r_col == CW'(IW-1));
   assign w_row_wrap = (r_row == RW'(IH-1));
   // Left columns of a row still hold the previous row's tail, top rows the previous frame.
   assign w_win_done = (r_row >= RW'(KY-1)) && (r_col >= CW'(KX-1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_col   <= '0;
         r_row   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         for (int ky = 0; ky < KY; ky++) begin
            for (int kx = 0; kx < KX; kx++) begin
               r_win[ky][kx] <= '0;
            end
         end
      end else begin
         r_valid <= i_in_valid && w_win_done;
         r_last  <= i_in_valid && w_col_wrap && w_row_wrap;
         if (i_in_valid) begin
            if (w_col_wrap) begin
               r_col <= '0;
               r_row <= w_row_wrap ? '0 : r_row + RW'(1);
            end else begin
               r_col <= r_col + CW'(1);
            end
            for (int ky = 0; ky < KY; ky++) begin
               for (int kx = 0; kx < KX-1; kx++) begin
                  r_win[ky][kx] <= r_win[ky][kx+1];
               end
               r_win[ky][KX-1] <= w_col_vec[ky];
            end
         end
      end
   end

   generate
      for (genvar ky = 0; ky < KY; ky++) begin : g_out_ky
         for (genvar kx = 0; kx < KX; kx++) begin : g_out_kx
            assign o_ot_fmap[(ky*KX+kx)*IBW +: IBW] = r_win[ky][kx];
         end
      end
   endgenerate

   assign o_ot_valid = r_valid;
   assign o_ot_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_stage2_conv_window_gen.sv
// ============================================================================
// tb_stage2_conv_window_gen : directed/table-driven bench for the window generator
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stage2_conv_window_gen;

   localparam int IW  = 12;
   localparam int IH  = 12;
   localparam int KX  = 5;
   localparam int KY  = 5;
   localparam int IBW = 20;
   localparam int FW  = KX*KY*IBW;
   localparam int OW  = IW-KX+1;
   localparam int NWIN = (IH-KY+1)*(IW-KX+1);

   logic           clk = 1'b0;
   logic           reset;
   logic           i_in_valid;
   logic [IBW-1:0] i_in_pixel;
   logic           o_ot_valid;
   logic [FW-1:0]  o_ot_fmap;
   logic           o_ot_last;

   always #5 clk = ~clk;

   stage2_conv_window_gen #(
      .IW(IW), .IH(IH), .KX(KX), .KY(KY), .IBW(IBW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_in_valid (i_in_valid),
      .i_in_pixel (i_in_pixel),
      .o_ot_valid (o_ot_valid),
      .o_ot_fmap  (o_ot_fmap),
      .o_ot_last  (o_ot_last)
   );

   typedef struct {
      int            t;
      logic [FW-1:0] fmap;
      logic          last;
      int            acc;
   } win_t;

   typedef struct {
      int             w;
      int             k;
      logic [IBW-1:0] exp;
   } vec_t;

   win_t q[$];
   vec_t vecs[8];
   int   tcur;
   int   n_cmp;
   int   n_err;

   function automatic logic [IBW-1:0] pix(input int base, input bit neg, input int idx);
      int v;
      v = base + idx + 1;
      return neg ? IBW'(-v) : IBW'(v);
   endfunction

   function automatic logic [IBW-1:0] elem(input logic [FW-1:0] f, input int k);
      return f[k*IBW +: IBW];
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // One clock: drive inputs, let the edge pass, sample 1 time unit later.
   task automatic step(input logic rst_v, input logic v, input logic [IBW-1:0] px, input int acc);
      reset      = rst_v;
      i_in_valid = v;
      i_in_pixel = px;
      @(posedge clk);
      #1;
      tcur++;
      if (o_ot_valid) q.push_back('{tcur, o_ot_fmap, o_ot_last, acc});
   endtask

   task automatic run_frame(input int base, input bit neg, input int gap_pct);
      for (int idx = 0; idx < IW*IH; idx++) begin
         while ($urandom_range(0, 99) < gap_pct) step(1'b0, 1'b0, '0, -1);
         step(1'b0, 1'b1, pix(base, neg, idx), idx);
      end
   endtask

   // Compares 64 captured windows starting at q[qoff] against the ramp model.
   task automatic check_frame(input string name, input int qoff, input int base, input bit neg);
      int oy, ox, bad_k;
      logic [IBW-1:0] e;
      check({name, " count"}, q.size() - qoff >= NWIN, 1);
      for (int w = 0; w < NWIN && qoff + w < q.size(); w++) begin
         oy = w / OW;
         ox = w % OW;
         bad_k = -1;
         for (int k = 0; k < KX*KY; k++) begin
            e = pix(base, neg, (oy + k/KX)*IW + ox + k%KX);
            if (elem(q[qoff+w].fmap, k) !== e && bad_k < 0) bad_k = k;
         end
         n_cmp++;
         if (bad_k >= 0) begin
            n_err++;
            $display("FAIL %s window %0d elem %0d: got 0x%0h expected 0x%0h", name, w, bad_k,
                     elem(q[qoff+w].fmap, bad_k),
                     pix(base, neg, (oy + bad_k/KX)*IW + ox + bad_k%KX));
         end
         check($sformatf("%s last w%0d", name, w), q[qoff+w].last, (w == NWIN-1));
         check($sformatf("%s completing pixel w%0d", name, w), q[qoff+w].acc,
               (oy+KY-1)*IW + ox + KX-1);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      tcur  = 0;
      vecs[0] = '{0,  0,  20'd1};
      vecs[1] = '{0,  12, 20'd27};
      vecs[2] = '{0,  24, 20'd53};
      vecs[3] = '{63, 24, 20'd144};
      vecs[4] = '{63, 0,  20'd92};
      vecs[5] = '{7,  0,  20'd8};
      vecs[6] = '{8,  4,  20'd17};
      vecs[7] = '{8,  20, 20'd61};

      // Reset state
      step(1'b1, 1'b0, '0, -1);
      step(1'b1, 1'b0, '0, -1);
      check("reset valid", o_ot_valid, 0);
      check("reset last", o_ot_last, 0);
      check("reset fmap zero", (o_ot_fmap == '0), 1);

      // Continuous ramp frame
      tcur = 0;
      q.delete();
      run_frame(0, 1'b0, 0);
      step(1'b0, 1'b0, '0, -1);
      check("ramp window count", q.size(), NWIN);
      if (q.size() > 0) check("ramp first window cycle", q[0].t, 53);
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].w < q.size())
            check($sformatf("ramp vec w%0d e%0d", vecs[i].w, vecs[i].k),
                  elem(q[vecs[i].w].fmap, vecs[i].k), vecs[i].exp);
         else
            check($sformatf("ramp vec w%0d missing", vecs[i].w), 0, 1);
      end
      check_frame("ramp", 0, 0, 1'b0);

      // Same ramp with ~30% idle cycles
      q.delete();
      run_frame(0, 1'b0, 30);
      step(1'b0, 1'b0, '0, -1);
      step(1'b0, 1'b0, '0, -1);
      check("gap window count", q.size(), NWIN);
      check_frame("gap", 0, 0, 1'b0);

      // Two back-to-back frames
      tcur = 0;
      q.delete();
      run_frame(0, 1'b0, 0);
      run_frame(1000, 1'b0, 0);
      step(1'b0, 1'b0, '0, -1);
      check("b2b window count", q.size(), 2*NWIN);
      if (q.size() > NWIN) begin
         check("b2b frame2 first cycle", q[NWIN].t, 197);
         check("b2b frame2 elem0", elem(q[NWIN].fmap, 0), 20'd1001);
      end
      check_frame("b2b f1", 0, 0, 1'b0);
      check_frame("b2b f2", NWIN, 1000, 1'b0);

      // Negated ramp
      q.delete();
      run_frame(0, 1'b1, 0);
      step(1'b0, 1'b0, '0, -1);
      if (q.size() > 0) check("neg w0 elem24", elem(q[0].fmap, 24), 20'hFFFCB);
      else check("neg no window", 0, 1);
      check_frame("neg", 0, 0, 1'b1);

      // Reset one cycle after 70 pixels, then a fresh ramp
      for (int idx = 0; idx < 70; idx++) step(1'b0, 1'b1, pix(0, 1'b0, idx), idx);
      step(1'b1, 1'b0, '0, -1);
      check("midreset valid after reset", o_ot_valid, 0);
      tcur = 0;
      q.delete();
      run_frame(0, 1'b0, 0);
      step(1'b0, 1'b0, '0, -1);
      check("midreset window count", q.size(), NWIN);
      if (q.size() > 0) check("midreset first cycle", q[0].t, 53);
      check_frame("midreset", 0, 0, 1'b0);

      // Reset held while pixels are offered
      for (int idx = 0; idx < 60; idx++) begin
         step(1'b1, 1'b1, pix(0, 1'b0, idx), idx);
         check($sformatf("held reset outputs c%0d", idx),
               {o_ot_valid, o_ot_last, (o_ot_fmap != '0)}, 3'b000);
      end
      step(1'b0, 1'b0, '0, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
